// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_pkg
//  Purpose : Shared pipeline constants, MEM-stage state encoding, writeback
//            bundle type and the jump-and-link value helper.
//  Contents: DATA_W (32) datapath/memory word width
//            ADDR_W (5)  data-memory word-address width
//            REG_W  (5)  register-file index width
//            PC_W   (5)  program-counter width
//  Revision: 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_W  = 5;
    localparam int PC_W   = 5;

    // IDLE: slot empty or non-memory op.  ACCESS: load/store awaiting ready.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  write_reg;
        logic              reg_wrenable;
    } wb_t;

    // Return address of a jump-and-link: pc+1 wrapping inside PC_W bits,
    // then zero-extended to the datapath width.
    function automatic logic [DATA_W-1:0] link_value(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] nxt;
        nxt = pc + PC_W'(1);
        return DATA_W'(nxt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_if
//  Purpose : Data-memory req/ready port between the MEM stage and memory.
//  Signals : dmem_req   request valid          (master -> slave)
//            dmem_we    1 = store, 0 = load    (master -> slave)
//            dmem_addr  word address           (master -> slave)
//            dmem_wdata store data             (master -> slave)
//            dmem_rdata load data              (slave  -> master)
//            dmem_ready access completes now   (slave  -> master)
//  Modports: master (MEM stage), slave (memory model)
//  Revision: 1.0  initial release
// ============================================================================
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage_access_ctrl
//  Purpose : IDLE/ACCESS state machine for the data-memory port. Generates
//            the request, the store/load select and the upstream stall.
//  Ports   : clk, rst        clock, synchronous active-high reset
//            in_is_mem       op waiting in EX is a load or store
//            m_mem_wrenable  op held in EX/MEM is a store
//            dmem_ready      memory completes this cycle
//            stall_out       freeze IF/ID/EX and EX/MEM this cycle
//            dmem_req        request valid
//            dmem_we         1 = store, 0 = load
//  Revision: 1.0  initial release
// ============================================================================
module mem_stage_access_ctrl
    import mem_stage_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic in_is_mem,
    input  wire logic m_mem_wrenable,
    input  wire logic dmem_ready,
    output logic      stall_out,
    output logic      dmem_req,
    output logic      dmem_we
);

    mem_state_t r_state;
    mem_state_t w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall_out    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        case (r_state)
            ACCESS: begin
                dmem_req  = 1'b1;
                dmem_we   = m_mem_wrenable;
                // A same-cycle ready retires the access without a stall.
                stall_out = ~dmem_ready;
            end
            default: ;
        endcase
        // EX/MEM loads whenever not stalled; the new occupant decides the state.
        if (!stall_out) begin
            w_state_next = in_is_mem ? ACCESS : IDLE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage
//  Purpose : EX/MEM pipeline register, data-memory access controller and
//            MEM/WB register. Stalls upstream while a load/store waits for
//            the memory, produces the writeback bundle and EX forwarding taps.
//  Ports   : clk, rst                      clock, sync active-high reset
//            in_pc/in_alu_result/in_rd2    EX-stage data
//            in_is_jump/in_reg_wrenable/
//            in_write_reg/in_mem_wrenable/
//            in_mem_to_reg                 EX-stage control
//            stall_out                     freeze IF/ID/EX this cycle
//            dmem (mem_stage_if.master)    data-memory req/ready port
//            out_wb_data/out_write_reg/
//            out_reg_wrenable              writeback bundle
//            fwd_mem_valid/reg/data        EX forwarding taps
//  Config  : MEM_STAGE_FWD_EN  enables forwarding taps (else tied 0)
//  Revision: 1.0  initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [PC_W-1:0]   in_pc,
    input  wire logic [DATA_W-1:0] in_alu_result,
    input  wire logic [DATA_W-1:0] in_rd2,
    input  wire logic              in_is_jump,
    input  wire logic              in_reg_wrenable,
    input  wire logic [REG_W-1:0]  in_write_reg,
    input  wire logic              in_mem_wrenable,
    input  wire logic              in_mem_to_reg,
    output logic                   stall_out,
    mem_stage_if.master            dmem,
    output logic [DATA_W-1:0]      out_wb_data,
    output logic [REG_W-1:0]       out_write_reg,
    output logic                   out_reg_wrenable,
    output logic                   fwd_mem_valid,
    output logic [REG_W-1:0]       fwd_mem_reg,
    output logic [DATA_W-1:0]      fwd_mem_data
);

    // EX/MEM slot
    logic [PC_W-1:0]   r_m_pc;
    logic [DATA_W-1:0] r_m_alu_result;
    logic [DATA_W-1:0] r_m_rd2;
    logic              r_m_is_jump;
    logic              r_m_reg_wrenable;
    logic [REG_W-1:0]  r_m_write_reg;
    logic              r_m_mem_wrenable;
    logic              r_m_mem_to_reg;

    wb_t               r_wb;

    logic              w_dmem_req;
    logic              w_dmem_we;
    logic              w_is_load;
    logic [DATA_W-1:0] w_alu_or_link;
    logic [DATA_W-1:0] w_wb_data;

    mem_stage_access_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .in_is_mem      (in_mem_wrenable | in_mem_to_reg),
        .m_mem_wrenable (r_m_mem_wrenable),
        .dmem_ready     (dmem.dmem_ready),
        .stall_out      (stall_out),
        .dmem_req       (w_dmem_req),
        .dmem_we        (w_dmem_we)
    );

    // Address and store data come straight from the slot, so they stay
    // stable for as long as the stall holds the slot.
    assign dmem.dmem_req   = w_dmem_req;
    assign dmem.dmem_we    = w_dmem_we;
    assign dmem.dmem_addr  = r_m_alu_result[ADDR_W-1:0];
    assign dmem.dmem_wdata = r_m_rd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_pc           <= '0;
            r_m_alu_result   <= '0;
            r_m_rd2          <= '0;
            r_m_is_jump      <= 1'b0;
            r_m_reg_wrenable <= 1'b0;
            r_m_write_reg    <= '0;
            r_m_mem_wrenable <= 1'b0;
            r_m_mem_to_reg   <= 1'b0;
        end else if (!stall_out) begin
            r_m_pc           <= in_pc;
            r_m_alu_result   <= in_alu_result;
            r_m_rd2          <= in_rd2;
            r_m_is_jump      <= in_is_jump;
            r_m_reg_wrenable <= in_reg_wrenable;
            r_m_write_reg    <= in_write_reg;
            r_m_mem_wrenable <= in_mem_wrenable;
            r_m_mem_to_reg   <= in_mem_to_reg;
        end
    end

    // An op flagged as both load and store behaves as a store.
    assign w_is_load     = r_m_mem_to_reg & ~r_m_mem_wrenable;
    assign w_alu_or_link = r_m_is_jump ? link_value(r_m_pc) : r_m_alu_result;
    assign w_wb_data     = w_is_load ? dmem.dmem_rdata : w_alu_or_link;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb <= '0;
        end else if (stall_out) begin
            // Bubble: only the enable drops, the rest of the bundle holds.
            r_wb.reg_wrenable <= 1'b0;
        end else begin
            r_wb.data         <= w_wb_data;
            r_wb.write_reg    <= r_m_write_reg;
            r_wb.reg_wrenable <= r_m_reg_wrenable & ~r_m_mem_wrenable;
        end
    end

    assign out_wb_data      = r_wb.data;
    assign out_write_reg    = r_wb.write_reg;
    assign out_reg_wrenable = r_wb.reg_wrenable;

`ifdef MEM_STAGE_FWD_EN
    // Loads are excluded: their value does not exist until the access ends.
    assign fwd_mem_valid = r_m_reg_wrenable & ~r_m_mem_to_reg & ~r_m_mem_wrenable
                           & (r_m_write_reg != '0);
    assign fwd_mem_reg   = r_m_write_reg;
    assign fwd_mem_data  = w_alu_or_link;
`else
    assign fwd_mem_valid = 1'b0;
    assign fwd_mem_reg   = '0;
    assign fwd_mem_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_stage
//  Purpose : Self-checking bench for mem_stage: directed vector table,
//            hand-written multi-cycle sequences and a randomized run checked
//            against a transaction-level reference model.
//  Config  : MEM_STAGE_FWD_EN selects the expected forwarding behaviour.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_pc;
    logic [31:0] in_alu_result;
    logic [31:0] in_rd2;
    logic        in_is_jump;
    logic        in_reg_wrenable;
    logic [4:0]  in_write_reg;
    logic        in_mem_wrenable;
    logic        in_mem_to_reg;
    logic        stall_out;
    logic [31:0] out_wb_data;
    logic [4:0]  out_write_reg;
    logic        out_reg_wrenable;
    logic        fwd_mem_valid;
    logic [4:0]  fwd_mem_reg;
    logic [31:0] fwd_mem_data;

    mem_stage_if bus ();

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_pc            (in_pc),
        .in_alu_result    (in_alu_result),
        .in_rd2           (in_rd2),
        .in_is_jump       (in_is_jump),
        .in_reg_wrenable  (in_reg_wrenable),
        .in_write_reg     (in_write_reg),
        .in_mem_wrenable  (in_mem_wrenable),
        .in_mem_to_reg    (in_mem_to_reg),
        .stall_out        (stall_out),
        .dmem             (bus),
        .out_wb_data      (out_wb_data),
        .out_write_reg    (out_write_reg),
        .out_reg_wrenable (out_reg_wrenable),
        .fwd_mem_valid    (fwd_mem_valid),
        .fwd_mem_reg      (fwd_mem_reg),
        .fwd_mem_data     (fwd_mem_data)
    );

    always #5 clk = ~clk;

`ifdef MEM_STAGE_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [4:0] pc, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic j, input logic w, input logic [4:0] rd,
                         input logic st, input logic ld);
        in_pc           = pc;
        in_alu_result   = alu;
        in_rd2          = rd2;
        in_is_jump      = j;
        in_reg_wrenable = w;
        in_write_reg    = rd;
        in_mem_wrenable = st;
        in_mem_to_reg   = ld;
    endtask

    task automatic nop();
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Directed single-cycle (non-memory) vectors
    typedef struct {
        logic [4:0]  pc;
        logic [31:0] alu;
        logic        jump;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_en;
        logic        exp_fwd;
    } vec_t;

    vec_t vecs[7];

    // Randomized-run model records
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          at_cyc;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } mem_exp_t;

    wb_exp_t  wbq[$];
    mem_exp_t memq[$];

    initial begin
        vecs[0] = '{5'd0,  32'h0000_1234, 1'b0, 1'b1, 5'd3,  32'h0000_1234, 1'b1, 1'b1};
        vecs[1] = '{5'd31, 32'h0000_0055, 1'b1, 1'b1, 5'd5,  32'h0000_0000, 1'b1, 1'b1};
        vecs[2] = '{5'd4,  32'h0000_0099, 1'b1, 1'b1, 5'd1,  32'h0000_0005, 1'b1, 1'b1};
        vecs[3] = '{5'd2,  32'h0000_CAFE, 1'b0, 1'b1, 5'd0,  32'h0000_CAFE, 1'b1, 1'b0};
        vecs[4] = '{5'd9,  32'h0000_0042, 1'b0, 1'b1, 5'd7,  32'h0000_0042, 1'b1, 1'b1};
        vecs[5] = '{5'd3,  32'h0000_0777, 1'b0, 1'b0, 5'd9,  32'h0000_0777, 1'b0, 1'b0};
        vecs[6] = '{5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};

        rst = 1'b1;
        nop();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'd0;
        tick();
        tick();

        // ---------------- reset state
        chk("rst_wb_en",   out_reg_wrenable, 0);
        chk("rst_wb_data", out_wb_data, 0);
        chk("rst_wb_reg",  out_write_reg, 0);
        chk("rst_req",     bus.dmem_req, 0);
        chk("rst_stall",   stall_out, 0);
        chk("rst_fwd_v",   fwd_mem_valid, 0);
        chk("rst_fwd_d",   fwd_mem_data, 0);
        rst = 1'b0;

        // ---------------- table: ALU / link ops, one-cycle latency
        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].alu, 32'h0, vecs[i].jump, vecs[i].wren, vecs[i].rd, 1'b0, 1'b0);
            tick();
            nop();
            #1;
            chk("tab_stall_a", stall_out, 0);
            chk("tab_fwd_valid", fwd_mem_valid, FWD_ON & vecs[i].exp_fwd);
            if (FWD_ON && vecs[i].exp_fwd) begin
                chk("tab_fwd_reg",  fwd_mem_reg,  vecs[i].rd);
                chk("tab_fwd_data", fwd_mem_data, vecs[i].exp_data);
            end else if (!FWD_ON) begin
                chk("tab_fwd_reg0",  fwd_mem_reg,  0);
                chk("tab_fwd_data0", fwd_mem_data, 0);
            end
            tick();
            chk("tab_wb_data", out_wb_data, vecs[i].exp_data);
            chk("tab_wb_reg",  out_write_reg, vecs[i].rd);
            chk("tab_wb_en",   out_reg_wrenable, vecs[i].exp_en);
            chk("tab_stall_b", stall_out, 0);
        end

        // ---------------- load r7 from addr 5, ready 3 cycles after req
        drive(5'd1, 32'h0000_0105, 32'h0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
        tick();
        nop();
        bus.dmem_ready = 1'b0;
        #1;
        chk("ld_fwd_valid", fwd_mem_valid, 0);
        for (int k = 0; k < 3; k++) begin
            bus.dmem_rdata = $urandom;
            #1;
            chk("ld_req",   bus.dmem_req, 1);
            chk("ld_we",    bus.dmem_we, 0);
            chk("ld_addr",  bus.dmem_addr, 5);
            chk("ld_stall", stall_out, 1);
            tick();
            chk("ld_bubble", out_reg_wrenable, 0);
        end
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_ready_stall", stall_out, 0);
        chk("ld_ready_addr",  bus.dmem_addr, 5);
        tick();
        bus.dmem_ready = 1'b0;
        chk("ld_wb_data", out_wb_data, 32'hDEAD_BEEF);
        chk("ld_wb_reg",  out_write_reg, 7);
        chk("ld_wb_en",   out_reg_wrenable, 1);
        chk("ld_req_off", bus.dmem_req, 0);

        // ---------------- store addr 0x1F, same-cycle ready
        drive(5'd2, 32'h0000_003F, 32'hA5A5_A5A5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        nop();
        bus.dmem_ready = 1'b1;
        #1;
        chk("st_req",   bus.dmem_req, 1);
        chk("st_we",    bus.dmem_we, 1);
        chk("st_addr",  bus.dmem_addr, 32'h1F);
        chk("st_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        chk("st_stall", stall_out, 0);
        tick();
        bus.dmem_ready = 1'b0;
        chk("st_wb_en",   out_reg_wrenable, 0);
        chk("st_req_off", bus.dmem_req, 0);

        // ---------------- reset during an access wait
        drive(5'd3, 32'h0000_0003, 32'h0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        tick();
        nop();
        #1;
        chk("rs_req_pre", bus.dmem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_req",    bus.dmem_req, 0);
        chk("rs_stall",  stall_out, 0);
        chk("rs_wb_en",  out_reg_wrenable, 0);
        chk("rs_wb_data", out_wb_data, 0);
        chk("rs_wb_reg", out_write_reg, 0);
        chk("rs_fwd",    fwd_mem_valid, 0);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h1111_1111;
        tick();
        bus.dmem_ready = 1'b0;
        chk("rs_late_en",   out_reg_wrenable, 0);
        chk("rs_late_data", out_wb_data, 0);
        tick();
        chk("rs_late_en2",  out_reg_wrenable, 0);

        // ---------------- randomized run against a transaction model
        begin
            int          n_instr   = 300;
            int          issued    = 0;
            int          budget    = 0;
            int          stall_cnt = 0;
            int          exp_stall = 0;
            int          cnt       = 0;
            bit          have      = 0;
            bit          mem_active = 0;
            logic [4:0]  c_pc, c_rd;
            logic [31:0] c_alu, c_rd2, c_rdata;
            logic        c_j, c_w, c_st, c_ld;
            int          c_lat, r;
            wb_exp_t     e;
            mem_exp_t    m;

            while ((issued < n_instr || wbq.size() > 0 || memq.size() > 0) && budget < 5000) begin
                budget++;
                // missed writeback: its due cycle passed unseen
                if (wbq.size() > 0 && wbq[0].at_cyc < cyc) begin
                    chk("rnd_wb_missing", 0, 1);
                    void'(wbq.pop_front());
                end
                if (out_reg_wrenable) begin
                    if (wbq.size() == 0) begin
                        chk("rnd_wb_spurious", 1, 0);
                    end else begin
                        e = wbq.pop_front();
                        chk("rnd_wb_reg",  out_write_reg, e.rd);
                        chk("rnd_wb_data", out_wb_data, e.data);
                        chk("rnd_wb_cycle", cyc, e.at_cyc);
                    end
                end

                // memory responder
                bus.dmem_ready = 1'b0;
                bus.dmem_rdata = $urandom;
                if (bus.dmem_req) begin
                    if (memq.size() == 0) begin
                        chk("rnd_req_spurious", 1, 0);
                        bus.dmem_ready = 1'b1;
                    end else begin
                        if (!mem_active) begin
                            mem_active = 1;
                            cnt = memq[0].lat;
                        end
                        chk("rnd_we",    bus.dmem_we, memq[0].we);
                        chk("rnd_addr",  bus.dmem_addr, memq[0].addr);
                        chk("rnd_wdata", bus.dmem_wdata, memq[0].wdata);
                        if (cnt == 0) begin
                            bus.dmem_ready = 1'b1;
                            bus.dmem_rdata = memq[0].rdata;
                            void'(memq.pop_front());
                            mem_active = 0;
                        end else begin
                            cnt--;
                        end
                    end
                end

                // instruction issue
                if (!have && issued < n_instr) begin
                    c_pc    = 5'($urandom_range(31, 0));
                    c_rd    = 5'($urandom_range(31, 0));
                    c_alu   = $urandom;
                    c_rd2   = $urandom;
                    c_rdata = $urandom;
                    c_j     = ($urandom_range(3, 0) == 0);
                    c_w     = ($urandom_range(3, 0) != 0);
                    r       = int'($urandom_range(7, 0));
                    c_ld    = (r < 2) || (r == 7);
                    c_st    = (r == 2) || (r == 3) || (r == 7);
                    c_lat   = int'($urandom_range(3, 0));
                    have    = 1;
                end
                if (have) drive(c_pc, c_alu, c_rd2, c_j, c_w, c_rd, c_st, c_ld);
                else      nop();
                #1;
                if (stall_out) stall_cnt++;
                if (have && !stall_out) begin
                    // enters EX/MEM at edge cyc+1; leaves 1 + wait cycles later
                    have = 0;
                    issued++;
                    if (c_ld || c_st) begin
                        m.we    = c_st;
                        m.addr  = c_alu[4:0];
                        m.wdata = c_rd2;
                        m.rdata = c_rdata;
                        m.lat   = c_lat;
                        memq.push_back(m);
                        exp_stall += c_lat;
                    end
                    if (c_w && !c_st) begin
                        e.rd     = c_rd;
                        e.data   = (c_ld) ? c_rdata :
                                   (c_j)  ? 32'((int'(c_pc) + 1) % 32) : c_alu;
                        e.at_cyc = cyc + 2 + ((c_ld || c_st) ? c_lat : 0);
                        wbq.push_back(e);
                    end
                end
                tick();
            end
            chk("rnd_drained", wbq.size() + memq.size(), 0);
            chk("rnd_issued",  issued, n_instr);
            chk("rnd_stalls",  stall_cnt, exp_stall);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
